// File: rtl/mem_access_unit_pkg.sv
// Shared types and constants for the MEM-stage load/store engine.
// Holds access-size codes, FSM state encoding, lane count and alignment helper.
package mem_access_unit_pkg;

    localparam int N_LANES = 4;

    localparam logic [1:0] MASK_BYTE = 2'b00;
    localparam logic [1:0] MASK_HALF = 2'b01;
    localparam logic [1:0] MASK_WORD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Codes 10 and 11 are both treated as a word access.
    function automatic logic is_misaligned(
        input logic [1:0] mask,
        input logic [1:0] addr_lo
    );
        logic mis;
        mis = 1'b0;
        if (mask == MASK_HALF) begin
            mis = addr_lo[0];
        end else if (mask[1]) begin
            mis = |addr_lo;
        end
        return mis;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Bundle of the upstream operation, memory bus and result signals.
// slave: the load/store unit side; master: the pipeline/memory side.
interface mem_access_unit_if #(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 32,
    parameter int NB_MASK = 2
);
    logic               i_valid;
    logic               o_ready;
    logic [NB_ADDR-1:0] i_addr;
    logic [NB_DATA-1:0] i_wr_data;
    logic [NB_MASK-1:0] i_mascara;
    logic               i_is_unsigned;
    logic               i_mem_read;
    logic               i_mem_write;
    logic               o_mem_req;
    logic               o_mem_we;
    logic [NB_ADDR-1:0] o_mem_addr;
    logic [NB_DATA-1:0] o_mem_wdata;
    logic [3:0]         o_mem_be;
    logic               i_mem_ack;
    logic [NB_DATA-1:0] i_mem_rdata;
    logic               o_valid;
    logic [NB_DATA-1:0] o_dato;
    logic [NB_MASK-1:0] o_mascara;
    logic               o_is_unsigned;
    logic               o_misaligned;
    logic               o_stall;

    modport slave (
        input  i_valid, i_addr, i_wr_data, i_mascara, i_is_unsigned,
        input  i_mem_read, i_mem_write, i_mem_ack, i_mem_rdata,
        output o_ready, o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata,
        output o_mem_be, o_valid, o_dato, o_mascara, o_is_unsigned,
        output o_misaligned, o_stall
    );

    modport master (
        output i_valid, i_addr, i_wr_data, i_mascara, i_is_unsigned,
        output i_mem_read, i_mem_write, i_mem_ack, i_mem_rdata,
        input  o_ready, o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata,
        input  o_mem_be, o_valid, o_dato, o_mascara, o_is_unsigned,
        input  o_misaligned, o_stall
    );

endinterface

// File: rtl/mem_access_unit_lane_align.sv
// mem_lane_align: combinational byte-lane logic for the load/store engine.
// In: addr_lo, mask, is_store, wr_data, rd_data. Out: be, wdata, rd_data (right-justified).
module mem_lane_align
    import mem_access_unit_pkg::*;
(
    input  logic [1:0]           i_addr_lo,
    input  logic [1:0]           i_mask,
    input  logic                 i_is_store,
    input  logic [N_LANES*8-1:0] i_wr_data,
    input  logic [N_LANES*8-1:0] i_rd_data,
    output logic [N_LANES-1:0]   o_be,
    output logic [N_LANES*8-1:0] o_wdata,
    output logic [N_LANES*8-1:0] o_rd_data
);

    logic [N_LANES*8-1:0] rd_shift;

    assign rd_shift = i_rd_data >> {i_addr_lo, 3'b000};

    always_comb begin
        o_be      = 4'b1111;
        o_wdata   = i_wr_data;
        o_rd_data = i_rd_data;
        case (i_mask)
            MASK_BYTE: begin
                o_be      = 4'b0001 << i_addr_lo;
                o_wdata   = {4{i_wr_data[7:0]}};
                o_rd_data = {24'b0, rd_shift[7:0]};
            end
            MASK_HALF: begin
                o_be      = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata   = {2{i_wr_data[15:0]}};
                o_rd_data = i_addr_lo[1] ? {16'b0, i_rd_data[31:16]}
                                         : {16'b0, i_rd_data[15:0]};
            end
            default: begin
                o_be      = 4'b1111;
                o_wdata   = i_wr_data;
                o_rd_data = i_rd_data;
            end
        endcase
        // Loads fetch the whole word; the lane is picked on return.
        if (!i_is_store) begin
            o_be = 4'b1111;
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store engine (IDLE -> REQ -> DONE) between EX/MEM and data memory.
// Ports: i_clock, i_reset (async, active-high), bus (slave). Optional watchdog: MEM_TIMEOUT_EN.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int NB_DATA        = 32,
    parameter int NB_ADDR        = 32,
    parameter int NB_MASK        = 2,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              i_clock,
    input  logic              i_reset,
    mem_access_unit_if.slave  bus
);

    state_t             state_q, state_d;
    logic [NB_ADDR-1:0] addr_q, addr_d;
    logic [NB_DATA-1:0] wdata_q, wdata_d;
    logic [NB_DATA-1:0] dato_q, dato_d;
    logic [NB_MASK-1:0] mask_q, mask_d;
    logic               uns_q, uns_d;
    logic               we_q, we_d;
    logic               mis_q, mis_d;

    logic [3:0]         lane_be;
    logic [NB_DATA-1:0] lane_wdata;
    logic [NB_DATA-1:0] lane_rdata;
    logic               mem_op;
    logic               bad_align;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    mem_lane_align u_align (
        .i_addr_lo  (addr_q[1:0]),
        .i_mask     (mask_q),
        .i_is_store (we_q),
        .i_wr_data  (wdata_q),
        .i_rd_data  (bus.i_mem_rdata),
        .o_be       (lane_be),
        .o_wdata    (lane_wdata),
        .o_rd_data  (lane_rdata)
    );

    assign mem_op    = bus.i_mem_read | bus.i_mem_write;
    assign bad_align = mem_op & is_misaligned(bus.i_mascara, bus.i_addr[1:0]);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        dato_d  = dato_q;
        mask_d  = mask_q;
        uns_d   = uns_q;
        we_d    = we_q;
        mis_d   = mis_q;
`ifdef MEM_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (bus.i_valid) begin
                    mask_d = bus.i_mascara;
                    uns_d  = bus.i_is_unsigned;
                    mis_d  = 1'b0;
                    unique case (1'b1)
                        !mem_op: begin
                            dato_d  = NB_DATA'(bus.i_addr);
                            mask_d  = NB_MASK'(MASK_WORD);
                            state_d = ST_DONE;
                        end
                        bad_align: begin
                            dato_d  = '0;
                            mis_d   = 1'b1;
                            state_d = ST_DONE;
                        end
                        default: begin
                            addr_d  = bus.i_addr;
                            wdata_d = bus.i_wr_data;
                            we_d    = bus.i_mem_write;
                            state_d = ST_REQ;
`ifdef MEM_TIMEOUT_EN
                            cnt_d   = '0;
`endif
                        end
                    endcase
                end
            end
            ST_REQ: begin
`ifdef MEM_TIMEOUT_EN
                cnt_d = cnt_q + 1'b1;
`endif
                if (bus.i_mem_ack) begin
                    dato_d  = we_q ? '0 : lane_rdata;
                    state_d = ST_DONE;
                end
`ifdef MEM_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    dato_d  = '0;
                    mis_d   = 1'b1;
                    state_d = ST_DONE;
                end
`endif
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            dato_q  <= '0;
            mask_q  <= '0;
            uns_q   <= 1'b0;
            we_q    <= 1'b0;
            mis_q   <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            dato_q  <= dato_d;
            mask_q  <= mask_d;
            uns_q   <= uns_d;
            we_q    <= we_d;
            mis_q   <= mis_d;
`ifdef MEM_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign bus.o_ready       = (state_q == ST_IDLE);
    assign bus.o_mem_req     = (state_q == ST_REQ);
    assign bus.o_mem_we      = we_q;
    assign bus.o_mem_addr    = {addr_q[NB_ADDR-1:2], 2'b00};
    assign bus.o_mem_wdata   = lane_wdata;
    assign bus.o_mem_be      = (state_q == ST_REQ) ? lane_be : 4'b0000;
    assign bus.o_valid       = (state_q == ST_DONE);
    assign bus.o_dato        = dato_q;
    assign bus.o_mascara     = mask_q;
    assign bus.o_is_unsigned = uns_q;
    assign bus.o_misaligned  = (state_q == ST_DONE) & mis_q;
    assign bus.o_stall       = (state_q != ST_IDLE) | bus.i_valid;

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: directed cases plus randomized operations.
// Expected results come from a size/offset arithmetic model and a result queue.
module tb_mem_access_unit;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mem_access_unit_if #(.NB_DATA(32), .NB_ADDR(32), .NB_MASK(2)) bus ();

    mem_access_unit #(
        .NB_DATA(32), .NB_ADDR(32), .NB_MASK(2), .TIMEOUT_CYCLES(16)
    ) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    typedef struct {
        logic [31:0] dato;
        logic [1:0]  mask;
        logic        uns;
        logic        mis;
        logic        req;
        logic        we;
        logic [31:0] maddr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    logic cur_live = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] last_dato, last_maddr, last_wdata;
    logic [3:0]  last_be;
    logic [1:0]  last_mask;
    logic        last_mis, last_we;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected behaviour from access size and byte offset.
    function automatic exp_t model(input logic [31:0] addr,
                                   input logic [31:0] wd,
                                   input logic [1:0] mask, input logic uns,
                                   input logic rd, input logic wr,
                                   input logic [31:0] rdata);
        exp_t e;
        int   size;
        int   a;
        a    = int'(addr % 4);
        size = (mask == 2'b00) ? 1 : (mask == 2'b01) ? 2 : 4;
        e.uns   = uns;
        e.mask  = mask;
        e.req   = 1'b0;
        e.we    = wr;
        e.maddr = addr - 32'(a);
        e.be    = 4'b0;
        e.wdata = 32'b0;
        e.mis   = 1'b0;
        e.dato  = 32'b0;
        if (!rd && !wr) begin
            e.dato = addr;
            e.mask = 2'b11;
        end else if (a % size != 0) begin
            e.mis = 1'b1;
        end else begin
            e.req = 1'b1;
            for (int i = 0; i < 4; i++) begin
                e.wdata[8*i +: 8] = wd[8*(i % size) +: 8];
                e.be[i] = !wr || (i >= a && i < a + size);
            end
            if (!wr) begin
                e.dato = (rdata >> (8 * a)) &
                         ((size == 4) ? 32'hFFFF_FFFF
                                      : (32'h1 << (8 * size)) - 32'h1);
            end
        end
        return e;
    endfunction

    // Compare process: request fields while requesting, results on each strobe.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.o_mem_req) begin
                if (!cur_live || !cur.req) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL spurious_req: got 1 expected 0");
                end else begin
                    chk("mem_addr", bus.o_mem_addr, cur.maddr);
                    chk("mem_we", 32'(bus.o_mem_we), 32'(cur.we));
                    chk("mem_be", 32'(bus.o_mem_be), 32'(cur.be));
                    if (cur.we) chk("mem_wdata", bus.o_mem_wdata, cur.wdata);
                end
            end
            if (bus.o_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL spurious_valid: got 1 expected 0");
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("dato", bus.o_dato, e.dato);
                    chk("mascara", 32'(bus.o_mascara), 32'(e.mask));
                    chk("is_unsigned", 32'(bus.o_is_unsigned), 32'(e.uns));
                    chk("misaligned", 32'(bus.o_misaligned), 32'(e.mis));
                end
            end
        end
    end

    task automatic drive(input logic [31:0] addr, input logic [31:0] wd,
                         input logic [1:0] mask, input logic uns,
                         input logic rd, input logic wr);
        bus.i_valid       = 1'b1;
        bus.i_addr        = addr;
        bus.i_wr_data     = wd;
        bus.i_mascara     = mask;
        bus.i_is_unsigned = uns;
        bus.i_mem_read    = rd;
        bus.i_mem_write   = wr;
    endtask

    // One complete operation; called at posedge+1 with the unit idle.
    task automatic do_op(input logic [31:0] addr, input logic [31:0] wd,
                         input logic [1:0] mask, input logic uns,
                         input logic rd, input logic wr,
                         input logic [31:0] rdata, input int waitc);
        exp_t e;
        e = model(addr, wd, mask, uns, rd, wr, rdata);
        chk("ready_idle", 32'(bus.o_ready), 32'd1);
        cur      = e;
        cur_live = 1'b1;
        exp_q.push_back(e);
        drive(addr, wd, mask, uns, rd, wr);
        #1;
        chk("stall_accept", 32'(bus.o_stall), 32'd1);
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
        if (e.req) begin
            for (int c = 0; c < waitc; c++) begin
                chk("req_wait", 32'(bus.o_mem_req), 32'd1);
                chk("stall_wait", 32'(bus.o_stall), 32'd1);
                chk("valid_wait", 32'(bus.o_valid), 32'd0);
                @(posedge clk);
                #1;
            end
            bus.i_mem_ack   = 1'b1;
            bus.i_mem_rdata = rdata;
            #1;
            chk("req_at_ack", 32'(bus.o_mem_req), 32'd1);
            last_be    = bus.o_mem_be;
            last_wdata = bus.o_mem_wdata;
            last_maddr = bus.o_mem_addr;
            last_we    = bus.o_mem_we;
            @(posedge clk);
            #1;
            bus.i_mem_ack   = 1'b0;
            bus.i_mem_rdata = $urandom;
        end else begin
            chk("no_req", 32'(bus.o_mem_req), 32'd0);
        end
        chk("valid_strobe", 32'(bus.o_valid), 32'd1);
        chk("stall_done", 32'(bus.o_stall), 32'd1);
        last_dato = bus.o_dato;
        last_mask = bus.o_mascara;
        last_mis  = bus.o_misaligned;
        @(posedge clk);
        #1;
        chk("valid_drop", 32'(bus.o_valid), 32'd0);
        cur_live = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.i_valid       = 1'b0;
        bus.i_addr        = '0;
        bus.i_wr_data     = '0;
        bus.i_mascara     = '0;
        bus.i_is_unsigned = 1'b0;
        bus.i_mem_read    = 1'b0;
        bus.i_mem_write   = 1'b0;
        bus.i_mem_ack     = 1'b0;
        bus.i_mem_rdata   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(bus.o_ready), 32'd1);
        chk("rst_req", 32'(bus.o_mem_req), 32'd0);
        chk("rst_valid", 32'(bus.o_valid), 32'd0);
        chk("rst_stall", 32'(bus.o_stall), 32'd0);
        chk("rst_be", 32'(bus.o_mem_be), 32'd0);
        chk("rst_we", 32'(bus.o_mem_we), 32'd0);
        chk("rst_maddr", bus.o_mem_addr, 32'd0);
        chk("rst_wdata", bus.o_mem_wdata, 32'd0);
        chk("rst_dato", bus.o_dato, 32'd0);
        chk("rst_mis", 32'(bus.o_misaligned), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        do_op(32'h0000_1003, 32'h0, 2'b00, 1'b0, 1'b1, 1'b0, 32'hA1B2_C3D4, 0);
        chk("t1_maddr", last_maddr, 32'h0000_1000);
        chk("t1_be", 32'(last_be), 32'hF);
        chk("t1_dato", last_dato, 32'h0000_00A1);
        chk("t1_mask", 32'(last_mask), 32'd0);

        do_op(32'h0000_2002, 32'h0000_BEEF, 2'b01, 1'b0, 1'b0, 1'b1, 32'h0, 4);
        chk("t2_be", 32'(last_be), 32'hC);
        chk("t2_wdata", last_wdata, 32'hBEEF_BEEF);
        chk("t2_we", 32'(last_we), 32'd1);
        chk("t2_dato", last_dato, 32'd0);

        do_op(32'h0000_3001, 32'h0, 2'b11, 1'b0, 1'b1, 1'b0, 32'h0, 0);
        chk("t3_mis", 32'(last_mis), 32'd1);
        chk("t3_dato", last_dato, 32'd0);

        do_op(32'h1234_5678, 32'h0, 2'b00, 1'b1, 1'b0, 1'b0, 32'h0, 0);
        chk("t4_dato", last_dato, 32'h1234_5678);
        chk("t4_mask", 32'(last_mask), 32'd3);

        do_op(32'h0000_5001, 32'h0000_005A, 2'b00, 1'b1, 1'b1, 1'b1, 32'h0, 1);
        chk("t5_be", 32'(last_be), 32'h2);
        chk("t5_wdata", last_wdata, 32'h5A5A_5A5A);
        chk("t5_we", 32'(last_we), 32'd1);

        do_op(32'h0000_6002, 32'h0, 2'b01, 1'b1, 1'b1, 1'b0, 32'h8765_4321, 2);
        chk("t6_dato", last_dato, 32'h0000_8765);

        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            logic        rd;
            logic        wr;
            a  = $urandom;
            if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
            rd = 1'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 4) != 0 && !rd && !wr) rd = 1'b1;
            do_op(a, $urandom, 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), rd, wr, $urandom,
                  int'($urandom_range(0, 5)));
        end

        // Reset while a load is in flight.
        cur      = model(32'h0000_7000, 32'h0, 2'b11, 1'b0, 1'b1, 1'b0, 32'h0);
        cur_live = 1'b1;
        drive(32'h0000_7000, 32'h0, 2'b11, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("rr_req_before", 32'(bus.o_mem_req), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rr_req", 32'(bus.o_mem_req), 32'd0);
        chk("rr_stall", 32'(bus.o_stall), 32'd0);
        chk("rr_ready", 32'(bus.o_ready), 32'd1);
        chk("rr_valid", 32'(bus.o_valid), 32'd0);
        cur_live = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        bus.i_mem_ack = 1'b1;
        @(posedge clk);
        #1;
        bus.i_mem_ack = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("rr_late_valid", 32'(bus.o_valid), 32'd0);
            chk("rr_late_ready", 32'(bus.o_ready), 32'd1);
            @(posedge clk);
            #1;
        end

`ifdef MEM_TIMEOUT_EN
        begin
            exp_t e;
            e = model(32'h0000_0040, 32'h0, 2'b11, 1'b0, 1'b1, 1'b0, 32'h0);
            cur      = e;
            cur_live = 1'b1;
            e.mis    = 1'b1;
            e.dato   = 32'h0;
            exp_q.push_back(e);
            drive(32'h0000_0040, 32'h0, 2'b11, 1'b0, 1'b1, 1'b0);
            @(posedge clk);
            #1;
            bus.i_valid = 1'b0;
            for (int c = 0; c < 16; c++) begin
                chk("to_req", 32'(bus.o_mem_req), 32'd1);
                @(posedge clk);
                #1;
            end
            chk("to_valid", 32'(bus.o_valid), 32'd1);
            chk("to_mis", 32'(bus.o_misaligned), 32'd1);
            chk("to_req_drop", 32'(bus.o_mem_req), 32'd0);
            @(posedge clk);
            #1;
            cur_live      = 1'b0;
            bus.i_mem_ack = 1'b1;
            @(posedge clk);
            #1;
            bus.i_mem_ack = 1'b0;
            for (int c = 0; c < 2; c++) begin
                chk("to_late_valid", 32'(bus.o_valid), 32'd0);
                @(posedge clk);
                #1;
            end
        end
`endif

        @(posedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
